// File: rtl/nco_sweep_ctrl.sv
// Linear phase-increment sweep scheduler feeding nco.phase_inc.
// Define NCO_SWEEP_BIDIR_EN for the cfg_bidir port and triangular sweeps.
module nco_sweep_ctrl #(
   parameter int INC_W   = 16,
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [INC_W-1:0]   cfg_start_inc,
   input  logic [INC_W-1:0]   cfg_stop_inc,
   input  logic [INC_W-1:0]   cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               cfg_repeat,
`ifdef NCO_SWEEP_BIDIR_EN
   input  logic               cfg_bidir,
`endif
   output logic [INC_W-1:0]   phase_inc,
   output logic               inc_valid,
   output logic               busy,
   output logic               done,
   output logic               err
);

`ifdef NCO_SWEEP_BIDIR_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DONE = 2'd2,
      DOWN = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DONE = 2'd2
   } state_t;
`endif

   state_t state, state_n;

   logic [INC_W-1:0]   pi_n;
   logic               valid_n;
   logic               busy_n;
   logic               done_n;
   logic               err_n;
   logic [DWELL_W-1:0] cnt, cnt_n;

   logic [INC_W-1:0]   start_r, start_n;
   logic [INC_W-1:0]   stop_r, stop_n;
   logic [INC_W-1:0]   step_r, step_n;
   logic [DWELL_W-1:0] dwell_r, dwell_n;
   logic               rep_r, rep_n;
`ifdef NCO_SWEEP_BIDIR_EN
   logic               bidir_r, bidir_n;
`endif

   logic [INC_W:0]     up_nxt;
   logic               up_ok;
   logic [INC_W:0]     s_plus;
   logic [INC_W-1:0]   wrap_val;
   logic               expire;
   logic               cfg_bad;
   logic               turn;

   // Widened sums keep the top-of-range test free of wrap-around.
   assign up_nxt   = {1'b0, phase_inc} + {1'b0, step_r};
   assign up_ok    = up_nxt <= {1'b0, stop_r};
   assign s_plus   = {1'b0, start_r} + {1'b0, step_r};
   assign wrap_val = (s_plus <= {1'b0, stop_r})
                   ? s_plus[INC_W-1:0] : start_r;
   assign expire   = cnt == '0;
   assign cfg_bad  = (cfg_step == '0)
                   || (cfg_start_inc > cfg_stop_inc);

`ifdef NCO_SWEEP_BIDIR_EN
   logic [INC_W-1:0] dn_diff;
   logic             dn_ok;

   assign turn    = bidir_r && (phase_inc > start_r);
   assign dn_diff = phase_inc - start_r;
   assign dn_ok   = dn_diff >= step_r;
`else
   assign turn    = 1'b0;
`endif

   always_comb begin
      state_n = state;
      pi_n    = phase_inc;
      valid_n = 1'b0;
      busy_n  = busy;
      done_n  = 1'b0;
      err_n   = 1'b0;
      cnt_n   = cnt;
      start_n = start_r;
      stop_n  = stop_r;
      step_n  = step_r;
      dwell_n = dwell_r;
      rep_n   = rep_r;
`ifdef NCO_SWEEP_BIDIR_EN
      bidir_n = bidir_r;
`endif

      case (state)
         IDLE: begin
            if (start && !abort) begin
               start_n = cfg_start_inc;
               stop_n  = cfg_stop_inc;
               step_n  = cfg_step;
               dwell_n = cfg_dwell;
               rep_n   = cfg_repeat;
`ifdef NCO_SWEEP_BIDIR_EN
               bidir_n = cfg_bidir;
`endif
               if (cfg_bad) begin
                  err_n = 1'b1;
               end else begin
                  pi_n    = cfg_start_inc;
                  valid_n = 1'b1;
                  busy_n  = 1'b1;
                  cnt_n   = cfg_dwell;
                  state_n = UP;
               end
            end
         end

         UP: begin
            if (!expire) begin
               cnt_n = cnt - 1'b1;
            end else if (up_ok) begin
               pi_n    = up_nxt[INC_W-1:0];
               valid_n = 1'b1;
               cnt_n   = dwell_r;
            end else if (turn) begin
`ifdef NCO_SWEEP_BIDIR_EN
               // Top is not repeated: first DOWN value goes out now.
               pi_n    = phase_inc - step_r;
               valid_n = 1'b1;
               cnt_n   = dwell_r;
               state_n = DOWN;
`endif
            end else if (rep_r) begin
               pi_n    = start_r;
               valid_n = 1'b1;
               cnt_n   = dwell_r;
            end else begin
               busy_n  = 1'b0;
               done_n  = 1'b1;
               state_n = DONE;
            end
         end

`ifdef NCO_SWEEP_BIDIR_EN
         DOWN: begin
            if (!expire) begin
               cnt_n = cnt - 1'b1;
            end else if (dn_ok) begin
               pi_n    = phase_inc - step_r;
               valid_n = 1'b1;
               cnt_n   = dwell_r;
            end else if (rep_r) begin
               pi_n    = wrap_val;
               valid_n = 1'b1;
               cnt_n   = dwell_r;
               state_n = UP;
            end else begin
               busy_n  = 1'b0;
               done_n  = 1'b1;
               state_n = DONE;
            end
         end
`endif

         DONE: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase

      if (abort && state != IDLE) begin
         state_n = IDLE;
         pi_n    = '0;
         valid_n = 1'b1;
         busy_n  = 1'b0;
         done_n  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         phase_inc <= '0;
         inc_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         cnt       <= '0;
         start_r   <= '0;
         stop_r    <= '0;
         step_r    <= '0;
         dwell_r   <= '0;
         rep_r     <= 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
         bidir_r   <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         phase_inc <= pi_n;
         inc_valid <= valid_n;
         busy      <= busy_n;
         done      <= done_n;
         err       <= err_n;
         cnt       <= cnt_n;
         start_r   <= start_n;
         stop_r    <= stop_n;
         step_r    <= step_n;
         dwell_r   <= dwell_n;
         rep_r     <= rep_n;
`ifdef NCO_SWEEP_BIDIR_EN
         bidir_r   <= bidir_n;
`endif
      end
   end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: sweep table plus repeat,
// abort, reset and (with NCO_SWEEP_BIDIR_EN) triangular sequences.
module tb_nco_sweep_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [15:0] cfg_start_inc;
   logic [15:0] cfg_stop_inc;
   logic [15:0] cfg_step;
   logic [15:0] cfg_dwell;
   logic        cfg_repeat;
`ifdef NCO_SWEEP_BIDIR_EN
   logic        cfg_bidir;
`endif
   logic [15:0] phase_inc;
   logic        inc_valid;
   logic        busy;
   logic        done;
   logic        err;

   nco_sweep_ctrl #(.INC_W(16), .DWELL_W(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .cfg_start_inc (cfg_start_inc),
      .cfg_stop_inc  (cfg_stop_inc),
      .cfg_step      (cfg_step),
      .cfg_dwell     (cfg_dwell),
      .cfg_repeat    (cfg_repeat),
`ifdef NCO_SWEEP_BIDIR_EN
      .cfg_bidir     (cfg_bidir),
`endif
      .phase_inc     (phase_inc),
      .inc_valid     (inc_valid),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   logic [15:0] model_pi;

   typedef struct {
      logic [15:0]        s;
      logic [15:0]        e;
      logic [15:0]        st;
      logic [15:0]        dw;
      int                 n;
      logic [0:5][15:0]   vals;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] pi,
                          input logic v, input logic b,
                          input logic d, input logic e);
      chk({tag, ".phase_inc"}, 32'(phase_inc), 32'(pi));
      chk({tag, ".inc_valid"}, 32'(inc_valid), 32'(v));
      chk({tag, ".busy"},      32'(busy),      32'(b));
      chk({tag, ".done"},      32'(done),      32'(d));
      chk({tag, ".err"},       32'(err),       32'(e));
   endtask

   task automatic set_cfg(input logic [15:0] s, input logic [15:0] e,
                          input logic [15:0] st, input logic [15:0] dw,
                          input logic rep);
      cfg_start_inc = s;
      cfg_stop_inc  = e;
      cfg_step      = st;
      cfg_dwell     = dw;
      cfg_repeat    = rep;
   endtask

   task automatic scramble_cfg();
      set_cfg(16'h1234, 16'h0001, 16'h0000, 16'h0007, 1'b1);
`ifdef NCO_SWEEP_BIDIR_EN
      cfg_bidir = 1'b1;
`endif
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      @(negedge clk);
      set_cfg(v.s, v.e, v.st, v.dw, 1'b0);
`ifdef NCO_SWEEP_BIDIR_EN
      cfg_bidir = 1'b0;
`endif
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble_cfg();
      if (v.n == 0) begin
         chk_out({tag, ".rej"}, model_pi, 1'b0, 1'b0, 1'b0, 1'b1);
         @(negedge clk);
         chk_out({tag, ".rej1"}, model_pi, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
         for (int k = 0; k < v.n; k++) begin
            for (int d = 0; d <= int'(v.dw); d++) begin
               chk_out($sformatf("%s.v%0d.d%0d", tag, k, d),
                       v.vals[k], d == 0, 1'b1, 1'b0, 1'b0);
               @(negedge clk);
            end
         end
         model_pi = v.vals[v.n-1];
         chk_out({tag, ".done"}, model_pi, 1'b0, 1'b0, 1'b1, 1'b0);
         @(negedge clk);
         chk_out({tag, ".idle"}, model_pi, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   logic [15:0] rep_seq [10];
`ifdef NCO_SWEEP_BIDIR_EN
   logic [15:0] bi_seq  [5];
   logic [15:0] bir_seq [9];
`endif

   initial begin
      tbl[0] = '{16'd100, 16'd400, 16'd100, 16'd2, 4,
                 {16'd100, 16'd200, 16'd300, 16'd400, 16'd0, 16'd0}};
      tbl[1] = '{16'd1000, 16'd2500, 16'd1000, 16'd0, 2,
                 {16'd1000, 16'd2000, 16'd0, 16'd0, 16'd0, 16'd0}};
      tbl[2] = '{16'hFF00, 16'hFFFF, 16'h0080, 16'd1, 2,
                 {16'hFF00, 16'hFF80, 16'd0, 16'd0, 16'd0, 16'd0}};
      tbl[3] = '{16'd5, 16'd50, 16'd0, 16'd0, 0,
                 {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
      tbl[4] = '{16'd500, 16'd400, 16'd10, 16'd0, 0,
                 {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
      tbl[5] = '{16'd7, 16'd7, 16'd3, 16'd0, 1,
                 {16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
      tbl[6] = '{16'd0, 16'd30, 16'd10, 16'd0, 4,
                 {16'd0, 16'd10, 16'd20, 16'd30, 16'd0, 16'd0}};
      rep_seq = '{16'd10, 16'd10, 16'd20, 16'd20, 16'd30,
                  16'd30, 16'd10, 16'd10, 16'd20, 16'd20};
`ifdef NCO_SWEEP_BIDIR_EN
      bi_seq  = '{16'd100, 16'd200, 16'd300, 16'd200, 16'd100};
      bir_seq = '{16'd100, 16'd200, 16'd300, 16'd200, 16'd100,
                  16'd200, 16'd300, 16'd200, 16'd100};
      cfg_bidir = 1'b0;
`endif

      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      set_cfg(16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
      model_pi = 16'd0;
      repeat (3) @(negedge clk);
      chk_out("reset", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

      // repeat sweep, abort during the second 20 of the second pass
      @(negedge clk);
      set_cfg(16'd10, 16'd30, 16'd10, 16'd1, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble_cfg();
      for (int c = 0; c < 10; c++) begin
         chk_out($sformatf("rep.c%0d", c), rep_seq[c],
                 (c % 2) == 0, 1'b1, 1'b0, 1'b0);
         if (c == 9) abort = 1'b1;
         @(negedge clk);
      end
      abort = 1'b0;
      chk_out("abort", 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk_out("abort1", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // start and abort together in IDLE: abort wins
      set_cfg(16'd50, 16'd60, 16'd5, 16'd0, 1'b0);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      chk_out("sa_ok", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_cfg(16'd50, 16'd60, 16'd0, 16'd0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk_out("sa_bad", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // start while busy is ignored
      set_cfg(16'd1, 16'd2, 16'd1, 16'd0, 1'b0);
      start = 1'b1;
      @(negedge clk);
      chk_out("sb.v0", 16'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      set_cfg(16'd9, 16'd90, 16'd9, 16'd0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk_out("sb.v1", 16'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk_out("sb.done", 16'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk_out("sb.idle", 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);

      // reset mid-sweep
      set_cfg(16'd100, 16'd400, 16'd100, 16'd2, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk_out("rs.pre", 16'd100, 1'b0, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_out("rs.post", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      chk_out("rs.idle", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef NCO_SWEEP_BIDIR_EN
      set_cfg(16'd100, 16'd300, 16'd100, 16'd0, 1'b0);
      cfg_bidir = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble_cfg();
      for (int c = 0; c < 5; c++) begin
         chk_out($sformatf("bi.c%0d", c), bi_seq[c],
                 1'b1, 1'b1, 1'b0, 1'b0);
         @(negedge clk);
      end
      chk_out("bi.done", 16'd100, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);

      set_cfg(16'd100, 16'd300, 16'd100, 16'd0, 1'b1);
      cfg_bidir = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble_cfg();
      for (int c = 0; c < 9; c++) begin
         chk_out($sformatf("bir.c%0d", c), bir_seq[c],
                 1'b1, 1'b1, 1'b0, 1'b0);
         if (c == 8) abort = 1'b1;
         @(negedge clk);
      end
      abort = 1'b0;
      chk_out("bir.abort", 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
